seg_vec_mem_ctrl: RTL and testbench

- Parametrised, multi-lane successor to the single-address segmented data memory map: sine ROM, input-pixel, output-pixel and start-switch regions in one flat address space.
- Accepts one vector request of LANES consecutive addresses. Serialises the lanes onto single-port, synchronous-read region memories, gathers the results and returns one response under a valid/ready handshake.
- Sits between the vector load/store unit and the memory arrays.
- Adds a registered read path, a synchronised start input, write protection of read-only regions, and an error flag for unmapped accesses.

---
 rtl/seg_vec_mem_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_seg_vec_mem_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_vec_mem_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : seg_vec_mem_ctrl
// Purpose  : Vector front end for the segmented data memory map (sine ROM,
//            input pixels, output pixels, start switch). A request covers
//            LANES consecutive addresses. The lanes are issued one per cycle
//            to the single-port, synchronous-read region memories. The read
//            data is gathered into one response, which is returned under a
//            valid/ready handshake.
// Ports    : clk, rst_n (synchronous, active low)
//            req_*   : vector request (valid/ready, we, base addr, wdata)
//            resp_*  : vector response (valid/ready, rdata, err)
//            start_io: asynchronous start switch
//            sin_*, in_*, out_* : region memory interfaces
// Revision : 1.0 - initial release
// ============================================================================
module seg_vec_mem_ctrl #(
  parameter int WIDTH      = 24,
  parameter int PIXEL      = 8,
  parameter int LANES      = 4,
  parameter int SIN_DEPTH  = 302,
  parameter int IN_DEPTH   = 90000,
  parameter int OUT_DEPTH  = 90000,
  parameter int START_ADDR = 180302
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [WIDTH-1:0]       req_addr,
  input  logic [LANES*PIXEL-1:0] req_wdata,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [LANES*WIDTH-1:0] resp_rdata,
  output logic                   resp_err,
  input  logic                   start_io,
  output logic [WIDTH-1:0]       sin_addr,
  input  logic [WIDTH-1:0]       sin_rdata,
  output logic [WIDTH-1:0]       in_addr,
  input  logic [PIXEL-1:0]       in_rdata,
  output logic [WIDTH-1:0]       out_addr,
  output logic                   out_we,
  output logic [PIXEL-1:0]       out_wdata,
  input  logic [PIXEL-1:0]       out_rdata
);

  localparam int c_lw = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [c_lw-1:0]  c_last_lane = c_lw'(LANES - 1);
  localparam logic [WIDTH-1:0] c_one       = WIDTH'(1);
  localparam logic [WIDTH-1:0] c_in_base   = WIDTH'(SIN_DEPTH);
  localparam logic [WIDTH-1:0] c_out_base  = WIDTH'(SIN_DEPTH + IN_DEPTH);
  localparam logic [WIDTH-1:0] c_out_end   = WIDTH'(SIN_DEPTH + IN_DEPTH + OUT_DEPTH);
  localparam logic [WIDTH-1:0] c_start     = WIDTH'(START_ADDR);

  localparam logic [2:0] c_reg_none  = 3'd0;
  localparam logic [2:0] c_reg_sin   = 3'd1;
  localparam logic [2:0] c_reg_in    = 3'd2;
  localparam logic [2:0] c_reg_out   = 3'd3;
  localparam logic [2:0] c_reg_start = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t                 r_state;
  logic [c_lw-1:0]        r_lane;        // lane currently driven on the memory ports
  logic                   r_we;
  logic [WIDTH-1:0]       r_cur_addr;    // full address of the lane currently issued
  logic [LANES*PIXEL-1:0] r_wdata;
  logic [2:0]             r_iss_region;  // region of the lane currently issued
  logic                   r_sync1;
  logic                   r_sync2;
  // Capture stage: describes the lane whose read data arrives this cycle
  logic                   r_cap_valid;
  logic [c_lw-1:0]        r_cap_lane;
  logic [2:0]             r_cap_region;
  logic                   r_cap_start;

  logic                   w_issue;
  logic [c_lw-1:0]        w_next_lane;
  logic [WIDTH-1:0]       w_iss_addr;
  logic                   w_iss_we;
  logic [PIXEL-1:0]       w_iss_wdata;
  logic [2:0]             w_iss_region;
  logic [WIDTH-1:0]       w_iss_local;
  logic                   w_iss_err;
  logic [WIDTH-1:0]       w_cap_data;

  // Lane 0 is issued straight from the request port at the accept edge.
  // Later lanes are issued from the latched copy, so each lane's address is
  // already on the memory port for the whole of its RUN cycle.
  assign w_issue     = (r_state == S_IDLE && req_valid && req_ready) ||
                       (r_state == S_RUN  && r_lane != c_last_lane);
  assign w_next_lane = r_lane + c_lw'(1);
  assign w_iss_addr  = (r_state == S_IDLE) ? req_addr : (r_cur_addr + c_one);
  assign w_iss_we    = (r_state == S_IDLE) ? req_we : r_we;
  assign w_iss_wdata = (r_state == S_IDLE) ? req_wdata[PIXEL-1:0]
                                           : r_wdata[w_next_lane*PIXEL +: PIXEL];

  always_comb begin
    w_iss_region = c_reg_none;
    w_iss_local  = '0;
    if (w_iss_addr == c_start) begin
      w_iss_region = c_reg_start;
    end else if (w_iss_addr < c_in_base) begin
      w_iss_region = c_reg_sin;
      w_iss_local  = w_iss_addr;
    end else if (w_iss_addr < c_out_base) begin
      w_iss_region = c_reg_in;
      w_iss_local  = w_iss_addr - c_in_base;
    end else if (w_iss_addr < c_out_end) begin
      w_iss_region = c_reg_out;
      w_iss_local  = w_iss_addr - c_out_base;
    end
  end

  // Only the output region is writable, and every access must be mapped
  assign w_iss_err = (w_iss_region == c_reg_none) ||
                     (w_iss_we && w_iss_region != c_reg_out);

  always_comb begin
    w_cap_data = '0;
    if (!r_we) begin
      case (r_cap_region)
        c_reg_sin:   w_cap_data = sin_rdata;
        c_reg_in:    w_cap_data = {{(WIDTH-PIXEL){1'b0}}, in_rdata};
        c_reg_out:   w_cap_data = {{(WIDTH-PIXEL){1'b0}}, out_rdata};
        c_reg_start: w_cap_data = {{(WIDTH-1){1'b0}}, r_cap_start};
        default:     w_cap_data = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_lane       <= '0;
      r_we         <= 1'b0;
      r_cur_addr   <= '0;
      r_wdata      <= '0;
      r_iss_region <= c_reg_none;
      r_sync1      <= 1'b0;
      r_sync2      <= 1'b0;
      r_cap_valid  <= 1'b0;
      r_cap_lane   <= '0;
      r_cap_region <= c_reg_none;
      r_cap_start  <= 1'b0;
      req_ready    <= 1'b0;
      resp_valid   <= 1'b0;
      resp_rdata   <= '0;
      resp_err     <= 1'b0;
      sin_addr     <= '0;
      in_addr      <= '0;
      out_addr     <= '0;
      out_we       <= 1'b0;
      out_wdata    <= '0;
    end else begin
      r_sync1     <= start_io;
      r_sync2     <= r_sync1;
      out_we      <= 1'b0;
      r_cap_valid <= 1'b0;

      if (r_cap_valid) begin
        resp_rdata[r_cap_lane*WIDTH +: WIDTH] <= w_cap_data;
      end

      if (w_issue) begin
        r_cur_addr   <= w_iss_addr;
        r_iss_region <= w_iss_region;
        // The error accumulator restarts with lane 0 of a new request
        resp_err     <= w_iss_err | (resp_err & (r_state == S_RUN));
        case (w_iss_region)
          c_reg_sin: sin_addr <= w_iss_local;
          c_reg_in:  in_addr  <= w_iss_local;
          c_reg_out: begin
            out_addr <= w_iss_local;
            if (w_iss_we) begin
              out_we    <= 1'b1;
              out_wdata <= w_iss_wdata;
            end
          end
          default: ;
        endcase
      end

      case (r_state)
        S_IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready  <= 1'b0;
            r_we       <= req_we;
            r_wdata    <= req_wdata;
            r_lane     <= '0;
            resp_rdata <= '0;
            r_state    <= S_RUN;
          end
        end
        S_RUN: begin
          r_cap_valid  <= 1'b1;
          r_cap_lane   <= r_lane;
          r_cap_region <= r_iss_region;
          r_cap_start  <= r_sync2;
          if (r_lane == c_last_lane) begin
            r_state <= S_DRAIN;
          end else begin
            r_lane <= w_next_lane;
          end
        end
        S_DRAIN: begin
          resp_valid <= 1'b1;
          r_state    <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seg_vec_mem_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_seg_vec_mem_ctrl
// Purpose  : Self-checking bench for seg_vec_mem_ctrl. It provides behavioural
//            region memories, a table of directed vector requests, and
//            sequences for reset, backpressure and abort.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_vec_mem_ctrl;

  localparam int WIDTH      = 24;
  localparam int PIXEL      = 8;
  localparam int LANES      = 4;
  localparam int SIN_DEPTH  = 302;
  localparam int IN_DEPTH   = 90000;
  localparam int OUT_DEPTH  = 90000;
  localparam int START_ADDR = 180302;
  localparam int OUT_BASE   = SIN_DEPTH + IN_DEPTH;
  localparam int NVEC       = 11;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   req_valid, req_ready, req_we;
  logic [WIDTH-1:0]       req_addr;
  logic [LANES*PIXEL-1:0] req_wdata;
  logic                   resp_valid, resp_ready, resp_err;
  logic [LANES*WIDTH-1:0] resp_rdata;
  logic                   start_io;
  logic [WIDTH-1:0]       sin_addr, sin_rdata, in_addr, out_addr;
  logic [PIXEL-1:0]       in_rdata, out_rdata, out_wdata;
  logic                   out_we;

  seg_vec_mem_ctrl #(
    .WIDTH(WIDTH), .PIXEL(PIXEL), .LANES(LANES), .SIN_DEPTH(SIN_DEPTH),
    .IN_DEPTH(IN_DEPTH), .OUT_DEPTH(OUT_DEPTH), .START_ADDR(START_ADDR)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .start_io(start_io),
    .sin_addr(sin_addr), .sin_rdata(sin_rdata),
    .in_addr(in_addr), .in_rdata(in_rdata),
    .out_addr(out_addr), .out_we(out_we), .out_wdata(out_wdata),
    .out_rdata(out_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] sin_f(input logic [WIDTH-1:0] a);
    return 24'hC00000 | a;
  endfunction

  function automatic logic [PIXEL-1:0] in_f(input logic [WIDTH-1:0] a);
    logic [31:0] t;
    t = 32'(a) * 32'd7 + 32'd3;
    return t[7:0];
  endfunction

  function automatic logic [PIXEL-1:0] out_init(input int i);
    logic [31:0] t;
    t = 32'(i);
    return t[7:0] ^ 8'hA5;
  endfunction

  function automatic logic [LANES*WIDTH-1:0] pack4(input logic [WIDTH-1:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction

  // Behavioural synchronous-read region memories
  logic [PIXEL-1:0] out_mem [OUT_DEPTH];
  logic             init_pending = 1'b1;

  always @(posedge clk) begin
    if (init_pending) begin
      for (int i = 0; i < OUT_DEPTH; i++) out_mem[i] <= out_init(i);
      init_pending <= 1'b0;
    end else begin
      sin_rdata <= (32'(sin_addr) < SIN_DEPTH) ? sin_f(sin_addr) : '0;
      in_rdata  <= in_f(in_addr);
      out_rdata <= (32'(out_addr) < OUT_DEPTH) ? out_mem[out_addr] : '0;
      if (out_we && 32'(out_addr) < OUT_DEPTH) out_mem[out_addr] <= out_wdata;
    end
  end

  typedef struct {
    int               addr;
    logic [PIXEL-1:0] data;
  } wr_t;
  wr_t wr_q[$];

  always @(negedge clk) begin
    if (out_we) wr_q.push_back('{int'(out_addr), out_wdata});
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Issue one request, wait for its response, then consume it.
  // lat counts cycles after the accept cycle (the accept cycle is cycle 0).
  task automatic do_req(input logic we, input logic [WIDTH-1:0] addr,
                        input logic [LANES*PIXEL-1:0] wdata,
                        output logic [LANES*WIDTH-1:0] rdata, output logic err,
                        output int lat);
    int k;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    k = 0;
    while (!req_ready && k < 20) begin @(negedge clk); k++; end
    chk("req_ready_before_accept", 128'(req_ready), 128'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat <= 20) begin @(negedge clk); lat++; end
    rdata = resp_rdata;
    err   = resp_err;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  typedef struct {
    logic                   we;
    logic [WIDTH-1:0]       addr;
    logic [LANES*PIXEL-1:0] wdata;
    logic                   start;
    logic [LANES*WIDTH-1:0] exp_rdata;
    logic                   exp_err;
  } vec_t;

  vec_t vecs [NVEC];

  initial begin
    logic [LANES*WIDTH-1:0] rd;
    logic                   er;
    logic [LANES*WIDTH-1:0] held;
    logic                   saw_valid;
    int lat, base, nexp;

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; resp_ready = 1'b0; start_io = 1'b0;

    vecs[0]  = '{1'b0, 24'd298, 32'h0, 1'b0,
                 pack4(sin_f(298), sin_f(299), sin_f(300), sin_f(301)), 1'b0};
    vecs[1]  = '{1'b0, 24'd300, 32'h0, 1'b0,
                 pack4(sin_f(300), sin_f(301), 24'(in_f(0)), 24'(in_f(1))), 1'b0};
    vecs[2]  = '{1'b1, 24'd90302, 32'h44332211, 1'b0, '0, 1'b0};
    vecs[3]  = '{1'b0, 24'd90302, 32'h0, 1'b0,
                 pack4(24'h000011, 24'h000022, 24'h000033, 24'h000044), 1'b0};
    vecs[4]  = '{1'b1, 24'd0, 32'hA1B2C3D4, 1'b0, '0, 1'b1};
    vecs[5]  = '{1'b0, 24'hFFFFFE, 32'h0, 1'b0,
                 pack4(24'h0, 24'h0, sin_f(0), sin_f(1)), 1'b1};
    vecs[6]  = '{1'b0, 24'd180302, 32'h0, 1'b0, '0, 1'b1};
    vecs[7]  = '{1'b0, 24'd180302, 32'h0, 1'b1,
                 pack4(24'h000001, 24'h0, 24'h0, 24'h0), 1'b1};
    vecs[8]  = '{1'b0, 24'd180300, 32'h0, 1'b1,
                 pack4(24'(out_init(89998)), 24'(out_init(89999)), 24'h000001, 24'h0), 1'b1};
    vecs[9]  = '{1'b1, 24'd90300, 32'hDDCCBBAA, 1'b0, '0, 1'b1};
    vecs[10] = '{1'b0, 24'd90300, 32'h0, 1'b0,
                 pack4(24'(in_f(89998)), 24'(in_f(89999)), 24'h0000CC, 24'h0000DD), 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 128'(req_ready), 128'd0);
    chk("rst_resp_valid", 128'(resp_valid), 128'd0);
    chk("rst_resp_rdata", 128'(resp_rdata), 128'd0);
    chk("rst_resp_err", 128'(resp_err), 128'd0);
    chk("rst_out_we", 128'(out_we), 128'd0);
    chk("rst_addrs", {32'(sin_addr), 32'(in_addr), 32'(out_addr), 32'(out_wdata)}, 128'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 128'(req_ready), 128'd1);

    for (int v = 0; v < NVEC; v++) begin
      start_io = vecs[v].start;
      repeat (3) @(negedge clk);
      base = wr_q.size();
      do_req(vecs[v].we, vecs[v].addr, vecs[v].wdata, rd, er, lat);
      chk($sformatf("v%0d_latency", v), 128'(lat), 128'(LANES + 2));
      chk($sformatf("v%0d_rdata", v), 128'(rd), 128'(vecs[v].exp_rdata));
      chk($sformatf("v%0d_err", v), 128'(er), 128'(vecs[v].exp_err));
      nexp = 0;
      for (int i = 0; i < LANES; i++) begin
        logic [WIDTH-1:0] a;
        a = vecs[v].addr + WIDTH'(i);
        if (vecs[v].we && 32'(a) >= OUT_BASE && 32'(a) < OUT_BASE + OUT_DEPTH) begin
          if (base + nexp < wr_q.size()) begin
            chk($sformatf("v%0d_wr%0d_addr", v, nexp),
                128'(wr_q[base+nexp].addr), 128'(32'(a) - OUT_BASE));
            chk($sformatf("v%0d_wr%0d_data", v, nexp),
                128'(wr_q[base+nexp].data), 128'(vecs[v].wdata[i*PIXEL +: PIXEL]));
          end
          nexp++;
        end
      end
      chk($sformatf("v%0d_wr_count", v), 128'(wr_q.size() - base), 128'(nexp));
    end

    // Backpressure: response must hold while resp_ready is low
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 24'd298;
    lat = 0;
    while (!req_ready && lat < 20) begin @(negedge clk); lat++; end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 20) begin @(negedge clk); lat++; end
    held = pack4(sin_f(298), sin_f(299), sin_f(300), sin_f(301));
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp%0d_valid", c), 128'(resp_valid), 128'd1);
      chk($sformatf("bp%0d_rdata", c), 128'(resp_rdata), 128'(held));
      chk($sformatf("bp%0d_req_ready", c), 128'(req_ready), 128'd0);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("bp_released_valid", 128'(resp_valid), 128'd0);
    chk("bp_released_ready", 128'(req_ready), 128'd1);

    // Reset during a RUN store aborts it
    @(negedge clk);
    base = wr_q.size();
    req_valid = 1'b1; req_we = 1'b1; req_addr = 24'd90302; req_wdata = 32'h88776655;
    lat = 0;
    while (!req_ready && lat < 20) begin @(negedge clk); lat++; end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("abort_first_pulse", 128'(out_we), 128'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_out_we", 128'(out_we), 128'd0);
    chk("abort_resp_valid", 128'(resp_valid), 128'd0);
    chk("abort_req_ready_in_rst", 128'(req_ready), 128'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_req_ready_after", 128'(req_ready), 128'd1);
    saw_valid = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (resp_valid) saw_valid = 1'b1;
    end
    chk("abort_no_response", 128'(saw_valid), 128'd0);
    chk("abort_pulse_count", 128'(wr_q.size() - base), 128'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
